// File: rtl/sp_ram_be_if.sv
// sp_ram_be_if: request/response bus of sp_ram_be; carries inj_par_err_i only when SP_RAM_PARITY_EN is defined
interface sp_ram_be_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic                req_i;
  logic                we_i;
  logic [DATA_W/8-1:0] be_i;
  logic [ADDR_W-1:0]   addr_i;
  logic [DATA_W-1:0]   wdata_i;
  logic [DATA_W-1:0]   rdata_o;
  logic                rvalid_o;
  logic                ready_o;
  logic                init_done_o;
  logic                addr_err_o;
  logic                parity_err_o;
`ifdef SP_RAM_PARITY_EN
  logic                inj_par_err_i;
`endif
  modport master (
`ifdef SP_RAM_PARITY_EN
    output inj_par_err_i,
`endif
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o, ready_o, init_done_o, addr_err_o, parity_err_o
  );
  modport slave (
`ifdef SP_RAM_PARITY_EN
    input  inj_par_err_i,
`endif
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rdata_o, rvalid_o, ready_o, init_done_o, addr_err_o, parity_err_o
  );
endinterface

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port byte-enable RAM with post-reset self-clear, range errors and optional per-byte parity (SP_RAM_PARITY_EN)
module sp_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input logic        clk_i,
  input logic        rst_n_i,
  sp_ram_be_if.slave bus
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;
  logic              init_done_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc;
  logic              wr;
  logic              rd;
  logic              in_rng;
  logic              rd_perr;
  logic              v1;
  logic              e1;
  logic              p1;
  logic              werr;
  logic [DATA_W-1:0] d1;
  logic              vo;
  logic              eo;
  logic              po;
  logic [DATA_W-1:0] d_o;
  assign acc    = rst_n_i && ready_q && bus.req_i;
  assign wr     = acc && bus.we_i;
  assign rd     = acc && !bus.we_i;
  assign in_rng = int'(bus.addr_i) < DEPTH;
  // clear sequencer: zeroes one word per cycle after reset, then opens the port
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      state       <= INIT;
      clr_cnt     <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state       <= RUN;
        ready_q     <= 1'b1;
        init_done_q <= 1'b1;
      end
    end
  // data array: clear writes during INIT, lane-masked writes in range afterwards
  always_ff @(posedge clk_i)
    if (rst_n_i && state == INIT) mem[clr_cnt] <= '0;
    else if (wr && in_rng)
      for (int n = 0; n < NB; n++)
        if (bus.be_i[n]) mem[bus.addr_i][8*n+:8] <= bus.wdata_i[8*n+:8];
`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] wpar;
  logic [NB-1:0] rpar;
  // even parity per lane of the incoming write (optionally corrupted) and of the addressed word
  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int n = 0; n < NB; n++) begin
      wpar[n] = ^bus.wdata_i[8*n+:8] ^ bus.inj_par_err_i;
      rpar[n] = ^mem[bus.addr_i][8*n+:8];
    end
  end
  assign rd_perr = in_rng && (rpar != par[bus.addr_i]);
  // parity array tracks the data array lane by lane
  always_ff @(posedge clk_i)
    if (rst_n_i && state == INIT) par[clr_cnt] <= '0;
    else if (wr && in_rng)
      for (int n = 0; n < NB; n++)
        if (bus.be_i[n]) par[bus.addr_i][n] <= wpar[n];
`else
  assign rd_perr = 1'b0;
`endif
  // first read stage; out-of-range writes flag immediately, out-of-range reads travel with the data
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      v1   <= 1'b0;
      e1   <= 1'b0;
      p1   <= 1'b0;
      werr <= 1'b0;
      d1   <= '0;
    end else begin
      v1   <= rd;
      e1   <= rd && !in_rng;
      p1   <= rd && rd_perr;
      werr <= wr && !in_rng;
      if (rd) d1 <= in_rng ? mem[bus.addr_i] : '0;
    end
  generate
    if (RD_LAT == 2) begin : g_lat2
      // extra output register; data holds between valid pulses
      always_ff @(posedge clk_i)
        if (!rst_n_i) {vo, eo, po, d_o} <= '0;
        else begin
          vo <= v1;
          eo <= e1;
          po <= p1;
          if (v1) d_o <= d1;
        end
    end else begin : g_lat1
      assign {vo, eo, po, d_o} = {v1, e1, p1, d1};
    end
  endgenerate
  assign bus.rdata_o      = d_o;
  assign bus.rvalid_o     = vo;
  assign bus.ready_o      = ready_q;
  assign bus.init_done_o  = init_done_q;
  assign bus.addr_err_o   = werr | eo;
  assign bus.parity_err_o = po;
endmodule

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
Parametrised single-port synchronous RAM with per-byte write enables, a req/ready handshake and configurable read latency. It clears its own contents after reset, and reports out-of-range accesses. It generalises the team's fixed 128x8 single-port RAM for use as buffer storage beneath FIFOs and packet stores. Write and read data use separate ports, so there is no bidirectional bus.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
DEPTH, 128, number of words; need not be a power of two
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
RD_LAT, 1, read latency in cycles from accepted request to rvalid_o; legal values 1 or 2

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  reset, synchronous, active-low
req_i  input  1  access request; accepted when req_i && ready_o
we_i  input  1  1 = write, 0 = read; sampled with req_i
be_i  input  DATA_W/8  byte enables for writes; bit n covers wdata_i[8n+7:8n]
addr_i  input  ADDR_W  word address
wdata_i  input  DATA_W  write data
rdata_o  output  DATA_W  read data; holds last value until the next rvalid_o
rvalid_o  output  1  one-cycle pulse, rdata_o valid
ready_o  output  1  block can accept a request this cycle
init_done_o  output  1  goes high once the post-reset clear completes, stays high
addr_err_o  output  1  one-cycle pulse: accepted request had addr_i >= DEPTH
parity_err_o  output  1  parity error pulse aligned with rvalid_o (see Optional Feature)

Behaviour:
- Reset values (rst_n_i=0 at a clock edge): rdata_o=0, rvalid_o=0, ready_o=0, init_done_o=0, addr_err_o=0, parity_err_o=0, clear counter=0, FSM goes to INIT. The memory array itself is not reset.
- FSM states:
  - INIT: writes 0 to word clr_cnt each cycle and increments clr_cnt. After writing DEPTH-1 it moves to RUN. INIT lasts exactly DEPTH cycles.
  - RUN: ready_o=1 and init_done_o=1, registered, asserted on the first cycle in RUN.
- While ready_o=0, req_i is ignored: no write, no rvalid_o.
- Write (req_i && we_i, accepted): at that clock edge, each byte lane with be_i[n]=1 takes wdata_i; other lanes are unchanged. be_i=0 is a no-op. No rvalid_o.
- Read (req_i && !we_i, accepted):
  - RD_LAT=1: rdata_o and rvalid_o update at the next edge.
  - RD_LAT=2: one extra output register stage; reads are fully pipelined, one accepted per cycle.
- One access per cycle (single port). A read immediately after a write to the same address returns the new data.
- Out of range (addr_i >= DEPTH, accepted):
  - Write is dropped and addr_err_o pulses on the next cycle.
  - Read pulses rvalid_o with rdata_o=0, and addr_err_o pulses in the same cycle as that rvalid_o.
- Reset mid-operation: in-flight reads are discarded (no rvalid_o), the FSM re-enters INIT, and the full clear restarts from address 0.
- Address wrap: none; addresses are never modified internally.

Optional Feature:
Macro SP_RAM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte, computed on write per enabled lane.
  - INIT writes parity 0 alongside the zero data.
  - Reads recompute parity; parity_err_o pulses with rvalid_o if any lane mismatches.
  - A debug input is present: inj_par_err_i, 1 bit. When high during an accepted write, the stored parity of every enabled lane is inverted.
- Not defined: no parity storage, inj_par_err_i is absent, and parity_err_o is tied to 0.

Test Plan:
1. Reset with DEPTH=128 -> ready_o=0 for exactly 128 cycles, then ready_o=init_done_o=1; a read of 0x7F returns 0x00000000.
2. Write 0xDEADBEEF to 0x04 with be_i=4'hF, then write 0x00001122 to 0x04 with be_i=4'h3, then read 0x04 -> rdata_o=0xDEAD1122 with rvalid_o 1 cycle after the read (RD_LAT=1) or 2 cycles after (RD_LAT=2).
3. Back-to-back reads of 0x04, 0x05, 0x06 on consecutive cycles with RD_LAT=2 -> three consecutive rvalid_o pulses carrying the data in order.
4. With DEPTH=100, write to address 0x70 -> addr_err_o pulses and no write occurs; a read of 0x70 -> rvalid_o with rdata_o=0 and addr_err_o=1 in the same cycle.
5. Assert rst_n_i for one cycle while a read is outstanding and in cycle 50 of INIT -> no rvalid_o, INIT restarts, ready_o returns after another 128 cycles, and previously written data reads 0.
6. With SP_RAM_PARITY_EN: write 0x000000A5 to 0x10 with be_i=4'h1 and inj_par_err_i=1, then read 0x10 -> parity_err_o=1 with rvalid_o; a clean write then read of 0x11 -> parity_err_o=0.
